// File: rtl/m31_addsub_vec.sv
// m31_addsub_vec: vectorised elastic add/subtract over the Mersenne-31 field
// (p = 2^31 - 1). Each beat carries LANES 31-bit elements sharing one opcode
// and tag; results are canonical (never equal to p).
//
// Parameters: LANES (1..32), STAGES (1 or 2), TAG_W.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid_i / in_ready_o  input handshake (in_ready_o is combinational)
//   op_i                     00 a+b, 01 a-b, 10 b-a, 11 2a
//   a_i, b_i                 operands, lane k at bits [31k+30:31k]
//   tag_i                    sideband returned with the result
//   out_valid_o/out_ready_i  output handshake
//   res_o, tag_o             result beat and its tag
//   nc_err_o                 only when M31_ADDSUB_RANGE_CHK_EN is defined:
//                            a lane read by the op held the value p
// Optional feature macro: M31_ADDSUB_RANGE_CHK_EN.
module m31_addsub_vec #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned STAGES = 1,
  parameter int unsigned TAG_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          op_i,
  input  logic [LANES*31-1:0] a_i,
  input  logic [LANES*31-1:0] b_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [LANES*31-1:0] res_o,
  output logic [TAG_W-1:0]    tag_o
`ifdef M31_ADDSUB_RANGE_CHK_EN
  ,
  output logic                nc_err_o
`endif
);

  localparam int unsigned EW = 31;
  localparam int unsigned DW = LANES * EW;
  localparam int unsigned SW = LANES * 32;
  localparam logic [30:0] P  = 31'h7FFF_FFFF;

  logic [SW-1:0] sum_c;
  logic [30:0]   a_l, b_l, x_l, y_l;
`ifdef M31_ADDSUB_RANGE_CHK_EN
  logic          err_c;
`endif

  // End-around-carry fold of every 32-bit lane sum, then map p to 0.
  function automatic logic [DW-1:0] fold_vec(input logic [SW-1:0] s);
    logic [DW-1:0] r;
    logic [30:0]   f;
    r = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      f = s[32*k +: 31] + 31'(s[32*k+31]);
      r[EW*k +: EW] = (f == P) ? 31'd0 : f;
    end
    return r;
  endfunction

  // Operand select per lane; ~v equals p - v, so subtraction is an add.
  always_comb begin
    sum_c = '0;
    a_l   = '0;
    b_l   = '0;
    x_l   = '0;
    y_l   = '0;
`ifdef M31_ADDSUB_RANGE_CHK_EN
    err_c = 1'b0;
`endif
    for (int k = 0; k < int'(LANES); k++) begin
      a_l = a_i[EW*k +: EW];
      b_l = b_i[EW*k +: EW];
      case (op_i)
        2'b00:   begin x_l = a_l; y_l = b_l;  end
        2'b01:   begin x_l = a_l; y_l = ~b_l; end
        2'b10:   begin x_l = b_l; y_l = ~a_l; end
        default: begin x_l = a_l; y_l = a_l;  end
      endcase
      sum_c[32*k +: 32] = {1'b0, x_l} + {1'b0, y_l};
`ifdef M31_ADDSUB_RANGE_CHK_EN
      // op 11 never reads b, so a non-canonical b is harmless there
      if ((a_l == P) || ((op_i != 2'b11) && (b_l == P))) err_c = 1'b1;
`endif
    end
  end

  if (STAGES == 1) begin : g_s1
    logic v_q;
    logic load_c;

    assign load_c      = ~v_q | out_ready_i;
    assign in_ready_o  = load_c;
    assign out_valid_o = v_q;

    // Single stage: sum, fold and canonicalise in one register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        res_o <= '0;
        tag_o <= '0;
`ifdef M31_ADDSUB_RANGE_CHK_EN
        nc_err_o <= 1'b0;
`endif
      end else if (load_c) begin
        v_q <= in_valid_i;
        if (in_valid_i) begin
          res_o <= fold_vec(sum_c);
          tag_o <= tag_i;
`ifdef M31_ADDSUB_RANGE_CHK_EN
          nc_err_o <= err_c;
`endif
        end
      end
    end
  end else if (STAGES == 2) begin : g_s2
    logic             v0_q, v1_q;
    logic             load0_c, load1_c;
    logic [SW-1:0]    s_q;
    logic [TAG_W-1:0] tag0_q;
`ifdef M31_ADDSUB_RANGE_CHK_EN
    logic             err0_q;
`endif

    // Empty upstream stage loads even while the output is stalled
    assign load1_c     = ~v1_q | out_ready_i;
    assign load0_c     = ~v0_q | load1_c;
    assign in_ready_o  = load0_c;
    assign out_valid_o = v1_q;

    // Stage 0 holds the raw 32-bit sums; stage 1 folds them
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v0_q   <= 1'b0;
        v1_q   <= 1'b0;
        s_q    <= '0;
        tag0_q <= '0;
        res_o  <= '0;
        tag_o  <= '0;
`ifdef M31_ADDSUB_RANGE_CHK_EN
        err0_q   <= 1'b0;
        nc_err_o <= 1'b0;
`endif
      end else begin
        if (load0_c) begin
          v0_q <= in_valid_i;
          if (in_valid_i) begin
            s_q    <= sum_c;
            tag0_q <= tag_i;
`ifdef M31_ADDSUB_RANGE_CHK_EN
            err0_q <= err_c;
`endif
          end
        end
        if (load1_c) begin
          v1_q <= v0_q;
          if (v0_q) begin
            res_o <= fold_vec(s_q);
            tag_o <= tag0_q;
`ifdef M31_ADDSUB_RANGE_CHK_EN
            nc_err_o <= err0_q;
`endif
          end
        end
      end
    end
  end else begin : g_bad
    $error("m31_addsub_vec: STAGES must be 1 or 2");
  end

  if ((LANES < 1) || (LANES > 32)) begin : g_bad_lanes
    $error("m31_addsub_vec: LANES must be in 1..32");
  end

endmodule

// File: tb/tb_m31_addsub_vec.sv
// Bench for m31_addsub_vec: one STAGES=1 and one STAGES=2 instance, a
// per-instance scoreboard fed at the input handshake and drained at the
// output handshake, a directed vector table, and stall/reset sequences.
module tb_m31_addsub_vec;

  localparam int unsigned LANES = 16;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned DW    = LANES * 31;
  localparam logic [30:0] P     = 31'h7FFF_FFFF;
  localparam longint      PL    = 64'd2147483647;

  typedef struct {
    logic [DW-1:0]    res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    int          lane;
    logic [30:0] a;
    logic [30:0] b;
    logic [30:0] exp;
    logic        err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       op;
  logic [DW-1:0]    a, b;
  logic [TAG_W-1:0] tag;
  logic             iv   [2];
  logic             ordy [2];
  logic             ir   [2];
  logic             ov   [2];
  logic [DW-1:0]    res  [2];
  logic [TAG_W-1:0] tago [2];
`ifdef M31_ADDSUB_RANGE_CHK_EN
  logic             err_o [2];
`endif

  int checks = 0;
  int errors = 0;
  int pend [2];

  always #5 clk = ~clk;

  m31_addsub_vec #(.LANES(LANES), .STAGES(1), .TAG_W(TAG_W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .op_i(op), .a_i(a), .b_i(b), .tag_i(tag),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .res_o(res[0]), .tag_o(tago[0])
`ifdef M31_ADDSUB_RANGE_CHK_EN
    , .nc_err_o(err_o[0])
`endif
  );

  m31_addsub_vec #(.LANES(LANES), .STAGES(2), .TAG_W(TAG_W)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .op_i(op), .a_i(a), .b_i(b), .tag_i(tag),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .res_o(res[1]), .tag_o(tago[1])
`ifdef M31_ADDSUB_RANGE_CHK_EN
    , .nc_err_o(err_o[1])
`endif
  );

  function automatic logic [30:0] canon(input logic [30:0] v);
    return (v == P) ? 31'd0 : v;
  endfunction

  // Reference: plain modular arithmetic on reduced operands
  function automatic exp_t model(input logic [1:0] o, input logic [DW-1:0] av,
                                 input logic [DW-1:0] bv, input logic [TAG_W-1:0] t);
    exp_t   e;
    longint x, y, r;
    e.res = '0;
    e.tag = t;
    e.err = 1'b0;
    for (int k = 0; k < int'(LANES); k++) begin
      x = longint'(canon(av[31*k +: 31]));
      y = longint'(canon(bv[31*k +: 31]));
      case (o)
        2'd0:    r = (x + y) % PL;
        2'd1:    r = (x - y + PL) % PL;
        2'd2:    r = (y - x + PL) % PL;
        default: r = (2 * x) % PL;
      endcase
      e.res[31*k +: 31] = 31'(r);
      if ((av[31*k +: 31] == P) || ((o != 2'd3) && (bv[31*k +: 31] == P))) e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_vec(input bit allow_p);
    logic [DW-1:0] v;
    for (int k = 0; k < int'(LANES); k++) begin
      if (allow_p && ($urandom_range(0, 15) == 0)) v[31*k +: 31] = P;
      else v[31*k +: 31] = 31'($urandom_range(0, 32'h7FFF_FFFE));
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard per instance, sampled on the falling edge
  for (genvar g = 0; g < 2; g++) begin : g_mon
    exp_t q[$];
    always @(negedge clk) begin
      exp_t e;
      logic exp_ir;
      if (!rst_n) begin
        q.delete();
      end else begin
        exp_ir = !((q.size() == g + 1) && !ordy[g]);
        checks++;
        if (ir[g] !== exp_ir) begin
          errors++;
          $display("FAIL in_ready dut%0d: got %b expected %b", g, ir[g], exp_ir);
        end
        if (ov[g] && ordy[g]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected beat dut%0d: tag %0h", g, tago[g]);
          end else begin
            e = q.pop_front();
            if ((res[g] !== e.res) || (tago[g] !== e.tag)) begin
              errors++;
              $display("FAIL result dut%0d: got tag %0h res %0h expected tag %0h res %0h",
                       g, tago[g], res[g], e.tag, e.res);
            end
`ifdef M31_ADDSUB_RANGE_CHK_EN
            checks++;
            if (err_o[g] !== e.err) begin
              errors++;
              $display("FAIL nc_err dut%0d: got %b expected %b", g, err_o[g], e.err);
            end
`endif
          end
        end
        if (iv[g] && ir[g]) q.push_back(model(op, a, b, tag));
      end
      pend[g] = q.size();
    end
  end

  task automatic check_reset(input int d);
    chk($sformatf("reset out_valid dut%0d", d), DW'(ov[d]), DW'(0));
    chk($sformatf("reset res dut%0d", d), res[d], '0);
    chk($sformatf("reset tag dut%0d", d), DW'(tago[d]), DW'(0));
    chk($sformatf("reset in_ready dut%0d", d), DW'(ir[d]), DW'(1));
`ifdef M31_ADDSUB_RANGE_CHK_EN
    chk($sformatf("reset nc_err dut%0d", d), DW'(err_o[d]), DW'(0));
`endif
  endtask

  task automatic run_table(input int d, input vec_t tv[12]);
    int lat;
    lat = d + 1;
    ordy[d] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      a = rand_vec(1'b0);
      b = rand_vec(1'b0);
      a[31*tv[i].lane +: 31] = tv[i].a;
      b[31*tv[i].lane +: 31] = tv[i].b;
      op  = tv[i].op;
      tag = TAG_W'(i + 16 * d);
      iv[d] = 1'b1;
      @(posedge clk); #1;
      iv[d] = 1'b0;
      chk($sformatf("first-cycle valid dut%0d vec%0d", d, i), DW'(ov[d]), DW'(lat == 1));
      if (lat == 2) begin
        @(posedge clk); #1;
      end
      chk($sformatf("latency valid dut%0d vec%0d", d, i), DW'(ov[d]), DW'(1));
      chk($sformatf("lane result dut%0d vec%0d", d, i), DW'(res[d][31*tv[i].lane +: 31]),
          DW'(tv[i].exp));
`ifdef M31_ADDSUB_RANGE_CHK_EN
      chk($sformatf("lane nc_err dut%0d vec%0d", d, i), DW'(err_o[d]), DW'(tv[i].err));
`endif
    end
  endtask

  task automatic new_beat(input int d, input int mode, input int idx);
    a   = rand_vec(mode == 0);
    b   = rand_vec(mode == 0);
    op  = 2'($urandom_range(0, 3));
    tag = (mode != 0) ? TAG_W'(idx) : TAG_W'($urandom);
    iv[d] = (mode != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  // mode 1: continuous beats tagged 0..n-1, out_ready pattern 1,0,0,1
  // mode 0: random data/valid/backpressure
  task automatic run_stream(input int d, input int n, input int mode);
    int   sent, cyc;
    logic hs;
    sent = 0;
    cyc  = 0;
    @(posedge clk); #1;
    new_beat(d, mode, sent);
    while ((sent < n) && (cyc < 4000)) begin
      if (mode != 0) ordy[d] = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else ordy[d] = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      hs = iv[d] & ir[d];
      if (hs) sent++;
      @(posedge clk); #1;
      cyc++;
      if (hs || !iv[d]) begin
        if (sent < n) new_beat(d, mode, sent);
        else iv[d] = 1'b0;
      end
    end
    iv[d] = 1'b0;
    chk($sformatf("stream accepted dut%0d", d), DW'(sent), DW'(n));
    ordy[d] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk($sformatf("stream drained dut%0d", d), DW'(pend[d]), DW'(0));
  endtask

  initial begin
    vec_t tv[12];
    tv[0]  = '{2'd0, 0,  31'h7FFFFFFE, 31'd1,        31'd0,        1'b0};
    tv[1]  = '{2'd0, 0,  31'h7FFFFFFE, 31'd2,        31'd1,        1'b0};
    tv[2]  = '{2'd1, 0,  31'd3,        31'd5,        31'h7FFFFFFD, 1'b0};
    tv[3]  = '{2'd2, 0,  31'd3,        31'd5,        31'd2,        1'b0};
    tv[4]  = '{2'd3, 0,  31'h40000000, 31'd0,        31'd1,        1'b0};
    tv[5]  = '{2'd1, 0,  31'h12345678, 31'h12345678, 31'd0,        1'b0};
    tv[6]  = '{2'd0, 5,  31'h7FFFFFFF, 31'd7,        31'd7,        1'b1};
    tv[7]  = '{2'd3, 2,  31'd5,        31'h7FFFFFFF, 31'd10,       1'b0};
    tv[8]  = '{2'd3, 15, 31'h7FFFFFFF, 31'd3,        31'd0,        1'b1};
    tv[9]  = '{2'd1, 9,  31'd0,        31'd1,        31'h7FFFFFFE, 1'b0};
    tv[10] = '{2'd2, 3,  31'h7FFFFFFF, 31'h7FFFFFFF, 31'd0,        1'b1};
    tv[11] = '{2'd0, 0,  31'h7FFFFFFF, 31'h7FFFFFFE, 31'h7FFFFFFE, 1'b1};

    rst_n = 1'b0;
    iv    = '{1'b0, 1'b0};
    ordy  = '{1'b1, 1'b1};
    op    = '0;
    a     = '0;
    b     = '0;
    tag   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;

    run_table(0, tv);
    run_table(1, tv);
    run_stream(1, 10, 1);
    run_stream(0, 150, 0);
    run_stream(1, 150, 0);

    // Reset with beats in flight on both instances
    @(posedge clk); #1;
    ordy = '{1'b0, 1'b0};
    a = rand_vec(1'b0); b = rand_vec(1'b0); op = 2'd0; tag = 8'hA5;
    iv = '{1'b1, 1'b1};
    @(posedge clk); #1;
    a = rand_vec(1'b0); b = rand_vec(1'b0); tag = 8'h5A;
    @(posedge clk); #1;
    iv = '{1'b0, 1'b0};
    chk("pre-reset valid dut0", DW'(ov[0]), DW'(1));
    chk("pre-reset valid dut1", DW'(ov[1]), DW'(1));
    chk("pre-reset in_ready dut1", DW'(ir[1]), DW'(0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    ordy = '{1'b1, 1'b1};
    repeat (4) @(posedge clk);
    #1;
    chk("post-reset idle dut0", DW'(ov[0]), DW'(0));
    chk("post-reset idle dut1", DW'(ov[1]), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
